// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the dRAM port arbiter: mode encoding, read-owner tags and width defaults.
// Optional grant statistics are enabled in the top with the ARB_STATS_EN macro.
package dram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    HOST_MODE = 1'b0,
    CPU_MODE  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side access bundle (req/we/addr/wdata in, gnt/rvalid/rdata back).
// The arbiter takes one instance per requester through the slave modport.
interface dram_port_arbiter_if
  import dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dram_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep owner-tag shift register; steers returning dRAM read data to its owner.
// rvalid and rdata are registered together, one cycle after the tag leaves the pipe.
module dram_port_arbiter_rd_tag_pipe
  import dram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  tag_t              i_tag,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata
);

  tag_t r_tag [RD_LAT];
  tag_t w_tag_out;

  assign w_tag_out = r_tag[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= TAG_NONE;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // ram_rdata is valid in the same cycle the tag reaches the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cpu_rvalid  <= 1'b0;
      o_host_rvalid <= 1'b0;
      o_cpu_rdata   <= '0;
      o_host_rdata  <= '0;
    end else begin
      o_cpu_rvalid  <= (w_tag_out == TAG_CPU);
      o_host_rvalid <= (w_tag_out == TAG_HOST);
      if (w_tag_out == TAG_CPU)  o_cpu_rdata  <= i_ram_rdata;
      if (w_tag_out == TAG_HOST) o_host_rdata <= i_ram_rdata;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbitrates the single-port dRAM between the processor core and the host port, with an
// aging counter that forces a host grant under contention. ARB_STATS_EN adds grant counters.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                power_ON_n,
  input  logic                processor_status,
  dram_port_arbiter_if.slave  cpu,
  dram_port_arbiter_if.slave  host,
`ifdef ARB_STATS_EN
  output logic [15:0]         stat_cpu_gnt,
  output logic [15:0]         stat_host_gnt,
  output logic [15:0]         stat_force,
`endif
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int WAIT_W = 8;

  mode_t             r_mode;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;

  logic w_at_limit;
  logic w_host_gnt;
  logic w_cpu_gnt;
  logic w_force;
  tag_t w_tag;

  // Grants are masked during reset so nothing reaches the RAM while power_ON_n is low
  always_comb begin
    w_at_limit = (r_wait_cnt == WAIT_W'(MAX_WAIT));
    w_host_gnt = power_ON_n && host.req &&
                 ((r_mode == HOST_MODE) || !cpu.req || w_at_limit);
    w_cpu_gnt  = power_ON_n && cpu.req && !w_host_gnt;
    w_force    = w_host_gnt && cpu.req && (r_mode == CPU_MODE) && w_at_limit;

    ram_addr  = r_addr_hold;
    ram_wdata = r_wdata_hold;
    ram_we    = 1'b0;
    w_tag     = TAG_NONE;
    if (w_host_gnt) begin
      ram_addr  = host.addr;
      ram_wdata = host.wdata;
      ram_we    = host.we;
      w_tag     = host.we ? TAG_NONE : TAG_HOST;
    end else if (w_cpu_gnt) begin
      ram_addr  = cpu.addr;
      ram_wdata = cpu.wdata;
      ram_we    = cpu.we;
      w_tag     = cpu.we ? TAG_NONE : TAG_CPU;
    end
  end

  assign cpu.gnt  = w_cpu_gnt;
  assign host.gnt = w_host_gnt;

  always_ff @(posedge clk or negedge power_ON_n) begin
    if (!power_ON_n) begin
      r_mode       <= HOST_MODE;
      r_wait_cnt   <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_mode <= processor_status ? CPU_MODE : HOST_MODE;
      if (w_host_gnt || w_cpu_gnt) begin
        r_addr_hold  <= ram_addr;
        r_wdata_hold <= ram_wdata;
      end
      // Aging only runs while the core owns priority and stays running
      if ((r_mode != CPU_MODE) || !processor_status || w_host_gnt)
        r_wait_cnt <= '0;
      else if (host.req && !w_at_limit)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  dram_port_arbiter_rd_tag_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk           (clk),
    .rst_n         (power_ON_n),
    .i_tag         (w_tag),
    .i_ram_rdata   (ram_rdata),
    .o_cpu_rvalid  (cpu.rvalid),
    .o_cpu_rdata   (cpu.rdata),
    .o_host_rvalid (host.rvalid),
    .o_host_rdata  (host.rdata)
  );

`ifdef ARB_STATS_EN
  logic w_status_rise;
  assign w_status_rise = processor_status && (r_mode == HOST_MODE);

  always_ff @(posedge clk or negedge power_ON_n) begin
    if (!power_ON_n) begin
      stat_cpu_gnt  <= '0;
      stat_host_gnt <= '0;
      stat_force    <= '0;
    end else if (w_status_rise) begin
      stat_cpu_gnt  <= '0;
      stat_host_gnt <= '0;
      stat_force    <= '0;
    end else begin
      if (w_cpu_gnt)  stat_cpu_gnt  <= sat_inc16(stat_cpu_gnt);
      if (w_host_gnt) stat_host_gnt <= sat_inc16(stat_host_gnt);
      if (w_force)    stat_force    <= sat_inc16(stat_force);
    end
  end
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed phases plus random traffic,
// checked each cycle against a queue-based reference model of the arbitration rules.
module tb_dram_port_arbiter;
  import dram_port_arbiter_pkg::*;

  localparam int AW       = 19;
  localparam int DW       = 8;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 15;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct packed {
    logic          host;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  logic clk = 1'b0;
  logic power_ON_n;
  logic processor_status;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_cpu_gnt, stat_host_gnt, stat_force;
  int m_sc, m_sh, m_sf;
`endif

  always #10 clk = ~clk;

  dram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  dram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host_if ();

  dram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk              (clk),
    .power_ON_n       (power_ON_n),
    .processor_status (processor_status),
    .cpu              (cpu_if),
    .host             (host_if),
`ifdef ARB_STATS_EN
    .stat_cpu_gnt     (stat_cpu_gnt),
    .stat_host_gnt    (stat_host_gnt),
    .stat_force       (stat_force),
`endif
    .ram_addr         (ram_addr),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  // dRAM macro stand-in with RD_LAT cycles of read latency
  logic [DW-1:0] env_mem [1024];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= env_mem[ram_addr[9:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ram_we) env_mem[ram_addr[9:0]] <= ram_wdata;
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  logic [DW-1:0] ref_mem [1024];
  op_t cq[$];
  op_t hq[$];
  rd_t rq[$];
  bit            m_run;
  int            m_wait;
  logic [AW-1:0] m_addr_hold;
  logic [DW-1:0] m_cpu_rdata, m_host_rdata;
  int cyc;
  int total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cpu_if.req  = (cq.size() > 0);
    host_if.req = (hq.size() > 0);
    if (cq.size() > 0) begin
      cpu_if.we = cq[0].we; cpu_if.addr = cq[0].addr; cpu_if.wdata = cq[0].wdata;
    end
    if (hq.size() > 0) begin
      host_if.we = hq[0].we; host_if.addr = hq[0].addr; host_if.wdata = hq[0].wdata;
    end
  endtask

  task automatic push_op(input bit to_host, input bit we, input int addr, input int wdata);
    op_t op;
    op.we = we; op.addr = AW'(addr); op.wdata = DW'(wdata);
    if (to_host) hq.push_back(op); else cq.push_back(op);
  endtask

  task automatic step(output bit cg, output bit hg);
    bit creq, hreq, ecg, ehg, ecv, ehv, eforce;
    op_t op;
    rd_t r;
    drive();
    #1;
    creq = (cq.size() > 0);
    hreq = (hq.size() > 0);
    ehg = hreq && (!m_run || !creq || (m_wait == MAX_WAIT));
    ecg = creq && !ehg;
    eforce = ehg && creq && m_run && (m_wait == MAX_WAIT);
    ecv = 1'b0; ehv = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.host) begin ehv = 1'b1; m_host_rdata = r.data; end
      else begin ecv = 1'b1; m_cpu_rdata = r.data; end
    end
    op = '0;
    if (ehg) op = hq[0]; else if (ecg) op = cq[0];
    chk("cpu_gnt", 32'(cpu_if.gnt), 32'(ecg));
    chk("host_gnt", 32'(host_if.gnt), 32'(ehg));
    chk("ram_we", 32'(ram_we), 32'((ehg || ecg) && op.we));
    chk("ram_addr", 32'(ram_addr), (ehg || ecg) ? 32'(op.addr) : 32'(m_addr_hold));
    if ((ehg || ecg) && op.we) chk("ram_wdata", 32'(ram_wdata), 32'(op.wdata));
    chk("cpu_rvalid", 32'(cpu_if.rvalid), 32'(ecv));
    chk("host_rvalid", 32'(host_if.rvalid), 32'(ehv));
    chk("cpu_rdata", 32'(cpu_if.rdata), 32'(m_cpu_rdata));
    chk("host_rdata", 32'(host_if.rdata), 32'(m_host_rdata));
`ifdef ARB_STATS_EN
    chk("stat_cpu", 32'(stat_cpu_gnt), 32'(m_sc));
    chk("stat_host", 32'(stat_host_gnt), 32'(m_sh));
    chk("stat_force", 32'(stat_force), 32'(m_sf));
    if (processor_status && !m_run) begin
      m_sc = 0; m_sh = 0; m_sf = 0;
    end else begin
      if (ecg && m_sc < 65535) m_sc++;
      if (ehg && m_sh < 65535) m_sh++;
      if (eforce && m_sf < 65535) m_sf++;
    end
`else
    if (eforce) m_addr_hold = m_addr_hold;
`endif
    if (ehg || ecg) begin
      if (op.we) ref_mem[op.addr[9:0]] = op.wdata;
      else begin
        r.host = ehg; r.data = ref_mem[op.addr[9:0]]; r.due = cyc + RD_LAT + 1;
        rq.push_back(r);
      end
      m_addr_hold = op.addr;
    end
    if (ehg) void'(hq.pop_front());
    if (ecg) void'(cq.pop_front());
    if (!m_run || !processor_status || ehg) m_wait = 0;
    else if (hreq && m_wait < MAX_WAIT) m_wait++;
    m_run = processor_status;
    cg = ecg; hg = ehg;
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit cg, hg;
    for (int i = 0; i < n; i++) step(cg, hg);
  endtask

  task automatic do_reset();
    power_ON_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive();
      #1;
      chk("rst_cpu_gnt", 32'(cpu_if.gnt), 0);
      chk("rst_host_gnt", 32'(host_if.gnt), 0);
      chk("rst_cpu_rvalid", 32'(cpu_if.rvalid), 0);
      chk("rst_host_rvalid", 32'(host_if.rvalid), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      chk("rst_cpu_rdata", 32'(cpu_if.rdata), 0);
      chk("rst_host_rdata", 32'(host_if.rdata), 0);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    rq.delete();
    m_run = 0; m_wait = 0; m_addr_hold = '0; m_cpu_rdata = '0; m_host_rdata = '0;
`ifdef ARB_STATS_EN
    m_sc = 0; m_sh = 0; m_sf = 0;
`endif
    power_ON_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    bit cg, hg;
    n = 0;
    while ((cq.size() > 0 || hq.size() > 0) && n < budget) begin
      step(cg, hg);
      n++;
    end
    chk("drain", 32'(cq.size() + hq.size()), 0);
    idle(RD_LAT + 2);
  endtask

  initial begin
    bit cg, hg;
    int n;
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    power_ON_n = 1'b0;
    processor_status = 1'b0;
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    host_if.req = 0; host_if.we = 0; host_if.addr = '0; host_if.wdata = '0;
    @(negedge clk);
    do_reset();

    // Preload the addresses used below through the host port
    for (int a = 0; a < 64; a++) push_op(1, 1, a, $urandom_range(0, 255));
    push_op(1, 1, 269, 10); push_op(1, 1, 270, 20); push_op(1, 1, 271, 30);
    push_op(1, 1, 5, 8'h55); push_op(1, 1, 6, 8'h66); push_op(1, 1, 527, 8'h77);
    drain(200);

    // Host read followed by reset while it is in flight
    push_op(1, 0, 269, 0);
    step(cg, hg);
    chk("rst_read_gnt", 32'(hg), 1);
    do_reset();
    idle(RD_LAT + 3);

    // Idle processor: three back-to-back host reads
    for (int a = 269; a <= 271; a++) push_op(1, 0, a, 0);
    for (int i = 0; i < 3; i++) begin
      step(cg, hg);
      chk("p2_host_gnt", 32'(hg), 1);
    end
    idle(RD_LAT + 2);
    chk("p2_last_rdata", 32'(host_if.rdata), 30);

    // Running processor hogging the port: host forced through on its 16th waiting cycle
    processor_status = 1'b1;
    idle(2);
    for (int a = 0; a < 40; a++) push_op(0, 0, a, 0);
    push_op(1, 0, 527, 0);
    n = 0;
    hg = 0;
    while (!hg && n < 40) begin
      step(cg, hg);
      n++;
    end
    chk("p3_force_cycle", 32'(n), 16);
    step(cg, hg);
    chk("p3_cpu_resumes", 32'(cg), 1);
    drain(80);
    chk("p3_host_rdata", 32'(host_if.rdata), 8'h77);

    // Host served in the gaps between processor reads
    for (int i = 0; i < 6; i++) begin
      push_op(0, 0, 5, 0);
      push_op(1, 0, 6, 0);
      step(cg, hg);
      chk("p4_cpu_first", 32'(cg), 1);
      step(cg, hg);
      chk("p4_host_gap", 32'(hg), 1);
      step(cg, hg);
    end
    idle(RD_LAT + 2);
    chk("p4_cpu_rdata", 32'(cpu_if.rdata), 8'h55);
    chk("p4_host_rdata", 32'(host_if.rdata), 8'h66);

    // Processor stops with a read in flight
    push_op(0, 0, 5, 0);
    step(cg, hg);
    processor_status = 1'b0;
    push_op(0, 0, 6, 0);
    push_op(0, 0, 5, 0);
    push_op(1, 0, 269, 0);
    step(cg, hg);
    chk("p5_cpu_before_switch", 32'(cg), 1);
    step(cg, hg);
    chk("p5_host_after_switch", 32'(hg), 1);
    drain(20);

    // Random traffic with occasional mode changes and writes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) processor_status = ~processor_status;
      if (cq.size() < 2 && $urandom_range(0, 2) != 0)
        push_op(0, $urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom_range(0, 255));
      if (hq.size() < 2 && $urandom_range(0, 3) == 0)
        push_op(1, $urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom_range(0, 255));
      step(cg, hg);
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM (dRAM; 19-bit address, 8-bit data) between two requesters: the downsampling processor core (cpu) and the external host load/readout port (host).
- Host owns the RAM while the processor is idle.
- The processor gets priority while running. An aging counter keeps host readout alive mid-run.
- Sits in the top level between the core, the host dRamAddr/dRamOut path, and the dRAM macro.

Parameters:
- ADDR_W, 19, dRAM address width
- DATA_W, 8, pixel width
- RD_LAT, 1, dRAM read latency in cycles (1..4)
- MAX_WAIT, 15, host cycles waited under contention before a forced host grant (1..255)

Ports:
- clk  in  1  system clock, 50 MHz
- power_ON_n  in  1  asynchronous active-low reset
- processor_status  in  1  1 = core running, 0 = idle
- cpu_req  in  1  core access request; held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_gnt  out  1  core access accepted this cycle
- cpu_rvalid  out  1  core read data valid
- cpu_rdata  out  DATA_W  core read data
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  same as cpu_*
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  same as cpu_*
- ram_addr  out  ADDR_W  to dRAM
- ram_we  out  1  to dRAM
- ram_wdata  out  DATA_W  to dRAM
- ram_rdata  in  DATA_W  from dRAM, valid RD_LAT cycles after the read address

Behaviour:
- Reset (power_ON_n=0, async):
  - mode = HOST_MODE, wait_cnt = 0, read-tag pipe cleared.
  - All gnt/rvalid = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, rdata outputs = 0.
- Grants are combinational from the current mode and requests. At most one gnt per cycle. ram_addr/ram_we/ram_wdata are muxed from the granted requester. With no grant: ram_we = 0 and ram_addr holds its last value.
- Mode FSM, registered; mode changes take effect the cycle after processor_status changes:
  - HOST_MODE (status=0): host has priority; cpu granted only if host_req=0.
  - CPU_MODE (status=1): cpu has priority; host granted if cpu_req=0, or if wait_cnt==MAX_WAIT.
  - HOST_MODE->CPU_MODE on status=1. CPU_MODE->HOST_MODE on status=0.
- wait_cnt:
  - Counts in CPU_MODE only.
  - Increments (saturating at MAX_WAIT) on each cycle with host_req=1 and host_gnt=0.
  - Clears on host_gnt, and on entering HOST_MODE.
- Forced host grant lasts exactly one cycle. cpu_gnt=0 in that cycle; the cpu request stays pending.
- Read return:
  - Each granted read pushes its owner tag into an RD_LAT-deep shift pipe.
  - When a tag emerges, the owner's rvalid=1 for one cycle and its rdata register captures ram_rdata. rdata holds between valid pulses.
  - Writes push an empty tag.
- Reads return in grant order. Back-to-back grants every cycle are allowed; throughput is 1 access/cycle.
- Mode change with reads in flight: the tag pipe drains normally; no read is lost or misrouted.
- Reset mid-read: in-flight reads are dropped, no rvalid asserted.
- Requests with gnt=0 have no side effects. A requester may change addr/we only after gnt.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs stat_cpu_gnt, stat_host_gnt, stat_force, each 16-bit saturating.
  - They count cpu grants, host grants and forced host grants.
  - Cleared by reset and on each 0->1 edge of processor_status.
- Undefined: none of these ports or counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package: mode state encoding (HOST_MODE, CPU_MODE), owner tag encoding (NONE, CPU, HOST), ADDR_W/DATA_W defaults shared with top_level_module.
- One natural sub-module: rd_tag_pipe (RD_LAT-deep owner-tag shift register with rvalid decode).

Test Plan:
- Reset during host read in flight, power_ON_n low 2 cycles -> no rvalid; all outputs 0; mode HOST_MODE.
- status=0; host reads addr 269, 270, 271 back to back, dRAM preloaded 10, 20, 30 -> host_gnt 3 consecutive cycles; host_rvalid 3 cycles later by RD_LAT=1; host_rdata 10, 20, 30 in order.
- status=1; cpu_req held continuously; host_req for addr 527 -> host_gnt exactly on cycle 16 of waiting (MAX_WAIT=15); cpu_gnt=0 that cycle only; wait_cnt back to 0.
- status=1; cpu read addr 5 and host read addr 6 alternating with cpu idle gaps -> host served in gaps; rdata routed to the correct owner; no cross-delivery.
- status toggles 1->0 with a cpu read in flight (RD_LAT=2) -> cpu_rvalid still delivered; next contended cycle grants host.
- ARB_STATS_EN: 100 cpu grants, 7 host grants, 2 forced -> stat counters read 100, 7, 2; cleared on the next status rise.
